// File: rtl/pwm_deadtime.sv
// Dead-time generator: turns the single-ended pwm waveform into a complementary
// high-side/low-side pair with programmable dead time and a synchronised fault kill.
module pwm_deadtime #(
   parameter int unsigned DT_W        = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic            mclk,
   input  logic            h_reset,
   input  logic            pwm_wfm_i,
   input  logic            cfg_dt_enb,
   input  logic [DT_W-1:0] cfg_dt_rise,
   input  logic [DT_W-1:0] cfg_dt_fall,
   input  logic            cfg_hs_inv,
   input  logic            cfg_ls_inv,
   input  logic            cfg_fault_enb,
   input  logic            cfg_fault_clr,
   input  logic            fault_in,
   output logic            pwm_hs_o,
   output logic            pwm_ls_o,
   output logic            dt_active,
   output logic            fault_sts
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LS_ON = 3'd1,
      DT_R  = 3'd2,
      HS_ON = 3'd3,
      DT_F  = 3'd4,
      FAULT = 3'd5
   } state_e;

   state_e                 state_q, state_d;
   state_e                 rise_tgt, fall_tgt;
   logic [DT_W-1:0]        cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hs_raw_q, hs_raw_d;
   logic                   ls_raw_q, ls_raw_d;
   logic                   dt_active_q, dt_active_d;
   logic                   fault_sts_q, fault_sts_d;
   logic                   fault_s;

   assign fault_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      // NOTE: every _d gets a default first so no path through the if/case infers a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      fault_sts_d = fault_sts_q;
      sync_d      = {sync_q[SYNC_STAGES-2:0], fault_in};

      // A zero dead time skips the dead state entirely.
      rise_tgt = (cfg_dt_rise == '0) ? HS_ON : DT_R;
      fall_tgt = (cfg_dt_fall == '0) ? LS_ON : DT_F;

      if (fault_s && cfg_fault_enb) begin
         state_d     = FAULT;
         cnt_d       = '0;
         fault_sts_d = 1'b1;
      end else if (state_q == FAULT) begin
         if (cfg_fault_clr && !fault_s) begin
            state_d     = IDLE;
            fault_sts_d = 1'b0;
         end
      end else if (!cfg_dt_enb) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pwm_wfm_i) begin
                  state_d = rise_tgt;
                  cnt_d   = cfg_dt_rise;
               end else begin
                  state_d = fall_tgt;
                  cnt_d   = cfg_dt_fall;
               end
            end
            LS_ON: begin
               if (pwm_wfm_i) begin
                  state_d = rise_tgt;
                  cnt_d   = cfg_dt_rise;
               end
            end
            HS_ON: begin
               if (!pwm_wfm_i) begin
                  state_d = fall_tgt;
                  cnt_d   = cfg_dt_fall;
               end
            end
            // A waveform reversal inside a dead window swallows the short pulse.
            DT_R: begin
               if (!pwm_wfm_i) begin
                  state_d = LS_ON;
                  cnt_d   = '0;
               end else if (cnt_q <= DT_W'(1)) begin
                  state_d = HS_ON;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - DT_W'(1);
               end
            end
            DT_F: begin
               if (pwm_wfm_i) begin
                  state_d = HS_ON;
                  cnt_d   = '0;
               end else if (cnt_q <= DT_W'(1)) begin
                  state_d = LS_ON;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - DT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      // Drive flops load from next state so outputs change on the deciding edge.
      hs_raw_d    = (state_d == HS_ON);
      ls_raw_d    = (state_d == LS_ON);
      dt_active_d = (state_d == DT_R) || (state_d == DT_F);
   end

   always_ff @(posedge mclk or posedge h_reset) begin
      if (h_reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sync_q      <= '0;
         hs_raw_q    <= 1'b0;
         ls_raw_q    <= 1'b0;
         dt_active_q <= 1'b0;
         fault_sts_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of the others.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sync_q      <= sync_d;
         hs_raw_q    <= hs_raw_d;
         ls_raw_q    <= ls_raw_d;
         dt_active_q <= dt_active_d;
         fault_sts_q <= fault_sts_d;
      end
   end

   assign pwm_hs_o  = hs_raw_q ^ cfg_hs_inv;
   assign pwm_ls_o  = ls_raw_q ^ cfg_ls_inv;
   assign dt_active = dt_active_q;
   assign fault_sts = fault_sts_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Self-checking bench for pwm_deadtime: a run-length reference model feeds a
// scoreboard queue; a random phase checks overlap and dead-gap invariants.
module tb_pwm_deadtime;

   localparam int DT_W        = 8;
   localparam int SYNC_STAGES = 2;

   logic            mclk = 1'b0;
   logic            h_reset;
   logic            pwm_wfm_i;
   logic            cfg_dt_enb;
   logic [DT_W-1:0] cfg_dt_rise;
   logic [DT_W-1:0] cfg_dt_fall;
   logic            cfg_hs_inv;
   logic            cfg_ls_inv;
   logic            cfg_fault_enb;
   logic            cfg_fault_clr;
   logic            fault_in;
   logic            pwm_hs_o;
   logic            pwm_ls_o;
   logic            dt_active;
   logic            fault_sts;

   pwm_deadtime #(.DT_W(DT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
      .mclk          (mclk),
      .h_reset       (h_reset),
      .pwm_wfm_i     (pwm_wfm_i),
      .cfg_dt_enb    (cfg_dt_enb),
      .cfg_dt_rise   (cfg_dt_rise),
      .cfg_dt_fall   (cfg_dt_fall),
      .cfg_hs_inv    (cfg_hs_inv),
      .cfg_ls_inv    (cfg_ls_inv),
      .cfg_fault_enb (cfg_fault_enb),
      .cfg_fault_clr (cfg_fault_clr),
      .fault_in      (fault_in),
      .pwm_hs_o      (pwm_hs_o),
      .pwm_ls_o      (pwm_ls_o),
      .dt_active     (dt_active),
      .fault_sts     (fault_sts)
   );

   always #5 mclk = ~mclk;

   typedef struct packed {
      logic hs;
      logic ls;
      logic dt;
      logic flt;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: which switch was last on, and how long the waveform has held its level.
   logic m_fresh  = 1'b1;
   logic m_last_w = 1'b0;
   int   m_run    = 0;
   int   m_side   = 0;  // 0: low side, 1: high side

   function automatic logic [3:0] obs();
      return {pwm_hs_o, pwm_ls_o, dt_active, fault_sts};
   endfunction

   function automatic void model_step(input logic w, input int rise, input int fall,
                                      output logic hs, output logic ls);
      if (m_fresh) begin
         m_run   = 1;
         m_side  = w ? 0 : 1;
         m_fresh = 1'b0;
      end else if (w != m_last_w) begin
         m_run = 1;
      end else begin
         m_run++;
      end
      m_last_w = w;
      hs = 1'b0;
      ls = 1'b0;
      if (w) hs = (m_side == 1) || (m_run > rise);
      else   ls = (m_side == 0) || (m_run > fall);
      if (hs) m_side = 1;
      if (ls) m_side = 0;
   endfunction

   task automatic drive_cycle(input logic w, input logic enb);
      exp_t e;
      logic hs, ls;
      pwm_wfm_i  = w;
      cfg_dt_enb = enb;
      if (!enb) begin
         hs = 1'b0;
         ls = 1'b0;
         m_fresh = 1'b1;
      end else begin
         model_step(w, int'(cfg_dt_rise), int'(cfg_dt_fall), hs, ls);
      end
      e.hs  = hs ^ cfg_hs_inv;
      e.ls  = ls ^ cfg_ls_inv;
      e.dt  = enb & ~hs & ~ls;
      e.flt = 1'b0;
      sb_q.push_back(e);
      @(posedge mclk);
      #1;
   endtask

   task automatic drive_forced(input exp_t e);
      sb_q.push_back(e);
      @(posedge mclk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      cfg_hs_inv = 1'b1;
      cfg_ls_inv = 1'b1;
      #1;
      sb_q.push_back(exp_t'(4'b1100));
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL reset_inv: got hs/ls/dt/flt=%b want %b", obs(), e);
      end
      cfg_hs_inv = 1'b0;
      cfg_ls_inv = 1'b0;
      #1;
      sb_q.push_back(exp_t'(4'b0000));
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL reset_val: got hs/ls/dt/flt=%b want %b", obs(), e);
      end
      @(posedge mclk);
      #1;
      h_reset = 1'b0;
      m_fresh = 1'b1;
   endtask

   task automatic test_square();
      exp_t e;
      int   dt_cnt;
      logic w;
      cfg_dt_rise = 8'd3;
      cfg_dt_fall = 8'd5;
      for (int h = 0; h < 4; h++) begin
         w = (h % 2 == 0);
         dt_cnt = 0;
         for (int c = 0; c < 20; c++) begin
            drive_cycle(w, 1'b1);
            if (dt_active) dt_cnt++;
            e = sb_q.pop_front();
            checks++;
            if (obs() !== e) begin
               errors++;
               $display("FAIL square h=%0d c=%0d: got %b want %b", h, c, obs(), e);
            end
         end
         checks++;
         if (dt_cnt !== (w ? 3 : 5)) begin
            errors++;
            $display("FAIL square_dt_len h=%0d: got %0d want %0d", h, dt_cnt, w ? 3 : 5);
         end
      end
      repeat (2) begin
         drive_cycle(1'b0, 1'b0);
         e = sb_q.pop_front();
      end
   endtask

   task automatic test_zero_dt();
      exp_t        e;
      logic [31:0] pat;
      pat = 32'hB38F_4DE2;
      cfg_dt_rise = 8'd0;
      cfg_dt_fall = 8'd0;
      for (int i = 0; i < 32; i++) begin
         drive_cycle(pat[i], 1'b1);
         e = sb_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL zero_dt i=%0d: got %b want %b", i, obs(), e);
         end
      end
      repeat (2) begin
         drive_cycle(1'b0, 1'b0);
         e = sb_q.pop_front();
      end
   endtask

   task automatic test_max_dt();
      exp_t e;
      int   dt_cnt = 0;
      cfg_dt_rise = 8'd255;
      cfg_dt_fall = 8'd1;
      for (int i = 0; i < 263; i++) begin
         drive_cycle(i >= 3, 1'b1);
         if (i >= 3 && dt_active) dt_cnt++;
         e = sb_q.pop_front();
         if (i < 5 || i > 255) begin
            checks++;
            if (obs() !== e) begin
               errors++;
               $display("FAIL max_dt i=%0d: got %b want %b", i, obs(), e);
            end
         end
      end
      checks++;
      if (dt_cnt !== 255) begin
         errors++;
         $display("FAIL max_dt_len: got %0d want 255", dt_cnt);
      end
      repeat (2) begin
         drive_cycle(1'b0, 1'b0);
         e = sb_q.pop_front();
      end
   endtask

   task automatic test_swallow();
      exp_t e;
      int   hs_seen = 0;
      cfg_dt_rise = 8'd8;
      cfg_dt_fall = 8'd2;
      for (int i = 0; i < 15; i++) begin
         drive_cycle((i >= 5) && (i < 9), 1'b1);
         if (pwm_hs_o) hs_seen++;
         e = sb_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL swallow i=%0d: got %b want %b", i, obs(), e);
         end
      end
      checks++;
      if (hs_seen !== 0) begin
         errors++;
         $display("FAIL swallow_hs: got %0d hs cycles want 0", hs_seen);
      end
      repeat (2) begin
         drive_cycle(1'b0, 1'b0);
         e = sb_q.pop_front();
      end
   endtask

   task automatic test_fault();
      exp_t e;
      cfg_dt_rise   = 8'd2;
      cfg_dt_fall   = 8'd2;
      cfg_fault_enb = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b1, 1'b1);
         e = sb_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL fault_pre i=%0d: got %b want %b", i, obs(), e);
         end
      end
      fault_in = 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
         drive_cycle(1'b1, 1'b1);
         e = sb_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL fault_sync i=%0d: got %b want %b", i, obs(), e);
         end
      end
      drive_forced(exp_t'(4'b0001));
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL fault_kill: got %b want %b", obs(), e);
      end
      cfg_fault_clr = 1'b1;
      drive_forced(exp_t'(4'b0001));
      cfg_fault_clr = 1'b0;
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL fault_clr_ignored: got %b want %b", obs(), e);
      end
      fault_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_forced(exp_t'(4'b0001));
         e = sb_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL fault_hold i=%0d: got %b want %b", i, obs(), e);
         end
      end
      cfg_fault_clr = 1'b1;
      drive_forced(exp_t'(4'b0000));
      cfg_fault_clr = 1'b0;
      m_fresh = 1'b1;
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL fault_exit: got %b want %b", obs(), e);
      end
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, 1'b1);
         e = sb_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL fault_post i=%0d: got %b want %b", i, obs(), e);
         end
      end
      cfg_fault_enb = 1'b0;
      fault_in      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, 1'b1);
         e = sb_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL fault_masked i=%0d: got %b want %b", i, obs(), e);
         end
      end
      fault_in = 1'b0;
      repeat (3) begin
         drive_cycle(1'b0, 1'b0);
         e = sb_q.pop_front();
      end
   endtask

   task automatic test_inv_enb();
      exp_t e;
      cfg_hs_inv  = 1'b1;
      cfg_ls_inv  = 1'b1;
      cfg_dt_rise = 8'd6;
      cfg_dt_fall = 8'd1;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 1'b1);
         e = sb_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL inv_ls i=%0d: got %b want %b", i, obs(), e);
         end
      end
      h_reset = 1'b1;
      #1;
      sb_q.push_back(exp_t'(4'b1100));
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL async_reset_inv: got %b want %b", obs(), e);
      end
      @(posedge mclk);
      #1;
      h_reset = 1'b0;
      m_fresh = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive_cycle(i >= 3, 1'b1);
         e = sb_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL inv_dtr i=%0d: got %b want %b", i, obs(), e);
         end
      end
      drive_cycle(1'b1, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL enb_off_dtr: got %b want %b", obs(), e);
      end
      cfg_hs_inv = 1'b0;
      cfg_ls_inv = 1'b0;
   endtask

   task automatic test_random();
      logic raw_hs, raw_ls, prev_hs, prev_ls, w;
      int   zc, last_side, flt_left;  // last_side: -1 none, 0 low, 1 high
      w = 1'b0; prev_hs = 1'b0; prev_ls = 1'b0;
      zc = 0; last_side = -1; flt_left = 0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         if (cyc % 500 == 0) begin
            cfg_dt_enb    = 1'b0;
            fault_in      = 1'b0;
            cfg_fault_clr = 1'b1;
            flt_left      = 0;
            repeat (18) @(posedge mclk);
            #1;
            cfg_fault_clr = 1'b0;
            cfg_dt_rise   = DT_W'($urandom_range(0, 15));
            cfg_dt_fall   = DT_W'($urandom_range(0, 15));
            cfg_hs_inv    = 1'($urandom_range(0, 1));
            cfg_ls_inv    = 1'($urandom_range(0, 1));
            cfg_fault_enb = 1'($urandom_range(0, 1));
            cfg_dt_enb    = 1'b1;
            prev_hs = 1'b0; prev_ls = 1'b0;
            zc = 18; last_side = -1;
         end
         if ($urandom_range(0, 7) == 0) w = ~w;
         pwm_wfm_i = w;
         if (flt_left > 0) begin
            flt_left--;
            fault_in = (flt_left > 0);
         end else if ($urandom_range(0, 299) == 0) begin
            fault_in = 1'b1;
            flt_left = $urandom_range(1, 6);
         end
         cfg_fault_clr = ($urandom_range(0, 19) == 0);
         @(posedge mclk);
         #1;
         raw_hs = pwm_hs_o ^ cfg_hs_inv;
         raw_ls = pwm_ls_o ^ cfg_ls_inv;
         checks++;
         if (raw_hs && raw_ls) begin
            errors++;
            $display("FAIL rnd_overlap cyc=%0d: hs=%b ls=%b want not both 1", cyc, raw_hs, raw_ls);
         end
         if (fault_sts) last_side = -1;
         if (raw_hs && !prev_hs && last_side == 0) begin
            checks++;
            if (zc < int'(cfg_dt_rise)) begin
               errors++;
               $display("FAIL rnd_rise_gap cyc=%0d: got %0d want >= %0d", cyc, zc, cfg_dt_rise);
            end
         end
         if (raw_ls && !prev_ls && last_side == 1) begin
            checks++;
            if (zc < int'(cfg_dt_fall)) begin
               errors++;
               $display("FAIL rnd_fall_gap cyc=%0d: got %0d want >= %0d", cyc, zc, cfg_dt_fall);
            end
         end
         if (raw_hs) begin
            last_side = 1;
            zc = 0;
         end else if (raw_ls) begin
            last_side = 0;
            zc = 0;
         end else begin
            zc++;
         end
         prev_hs = raw_hs;
         prev_ls = raw_ls;
         if ($urandom_range(0, 1999) == 0) begin
            #2 h_reset = 1'b1;
            #2 h_reset = 1'b0;
            last_side = -1;
         end
      end
      cfg_dt_enb    = 1'b0;
      cfg_hs_inv    = 1'b0;
      cfg_ls_inv    = 1'b0;
      cfg_fault_clr = 1'b0;
      fault_in      = 1'b0;
   endtask

   initial begin
      h_reset       = 1'b1;
      pwm_wfm_i     = 1'b0;
      cfg_dt_enb    = 1'b0;
      cfg_dt_rise   = '0;
      cfg_dt_fall   = '0;
      cfg_hs_inv    = 1'b0;
      cfg_ls_inv    = 1'b0;
      cfg_fault_enb = 1'b0;
      cfg_fault_clr = 1'b0;
      fault_in      = 1'b0;
      repeat (2) @(posedge mclk);
      #1;
      test_reset();
      test_square();
      test_zero_dt();
      test_max_dt();
      test_swallow();
      test_fault();
      test_inv_enb();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
